// File: rtl/panel_cursor_pkg.sv
// ---------------------------------------------------------------------------
// panel_cursor_pkg
// Shared definitions for the front-panel cursor controller:
//   - PS/2 set-2 make codes for the arrow keys and the 0/1/2 digit keys
//   - cursor action encoding driven onto the switch/LED panel
//   - momentary-hold FSM state encoding
//   - clog2_min1: $clog2 that never returns 0, so one-entry dimensions
//     still get a legal one-bit register
// ---------------------------------------------------------------------------
package panel_cursor_pkg;

   localparam logic [7:0] KEY_UP = 8'h75;
   localparam logic [7:0] KEY_DN = 8'h72;
   localparam logic [7:0] KEY_LT = 8'h6B;
   localparam logic [7:0] KEY_RT = 8'h74;
   localparam logic [7:0] KEY_0  = 8'h45;
   localparam logic [7:0] KEY_1  = 8'h16;
   localparam logic [7:0] KEY_2  = 8'h1E;

   typedef enum logic [1:0] {
      ACT_OFF  = 2'd0,
      ACT_ON   = 2'd1,
      ACT_ALT  = 2'd2,
      ACT_MOVE = 2'd3
   } action_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HELD     = 2'd1,
      REL_WAIT = 2'd2
   } state_e;

   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/ps2_key_event.sv
// ---------------------------------------------------------------------------
// ps2_key_event
// Registers the hps_io ps2_key bus once and turns the toggle bit into a
// one-cycle event pulse.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   ps2_key   in   [7:0] scancode, [8] extended, [9] make, [10] toggle
//   key_evt   out  one-cycle pulse, one per ps2_key[10] transition
//   key_make  out  1 = make, 0 = break (valid with key_evt)
//   key_code  out  scancode (valid with key_evt)
// The extended flag is deliberately dropped: E0-prefixed arrows behave the
// same as the keypad arrows.
// ---------------------------------------------------------------------------
module ps2_key_event (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   output logic        key_evt,
   output logic        key_make,
   output logic [7:0]  key_code
);

   logic       toggle_reg;
   logic       toggle_prev;
   logic       make_reg;
   logic [7:0] code_reg;
   logic       unused_ext;

   assign unused_ext = ps2_key[8];

   // Single input register stage; toggle_prev trails it by one clock so a
   // difference between the two marks exactly one new key event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         toggle_reg  <= 1'b0;
         toggle_prev <= 1'b0;
         make_reg    <= 1'b0;
         code_reg    <= 8'h00;
      end else begin
         toggle_reg  <= ps2_key[10];
         toggle_prev <= toggle_reg;
         make_reg    <= ps2_key[9];
         code_reg    <= ps2_key[7:0];
      end
   end

   assign key_evt  = toggle_reg ^ toggle_prev;
   assign key_make = make_reg;
   assign key_code = code_reg;

endmodule

// File: rtl/panel_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// panel_cursor_ctrl
// Keyboard-driven cursor over a COLS x ROWS front-panel switch grid. Arrow
// keys move the cursor, the 0/1/2 keys drive the switch under it. Switches
// flagged in MOMENTARY_MASK turn themselves off when the key is released,
// but only after being on for at least MIN_HOLD_CYCLES clocks.
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   ps2_key        in   hps_io ps2_key bus (11 bits)
//   cursor_index   out  row*COLS+col
//   cursor_action  out  0=off 1=on 2=alt/down 3=moved
//   cursor_strobe  out  one-cycle pulse when index or action changes
//   cursor_busy    out  high while a momentary hold is in progress
// Build option:
//   CURSOR_WRAP_EN  defined   -> cursor wraps around the grid edges
//                   undefined -> cursor saturates at the grid edges
// ---------------------------------------------------------------------------
module panel_cursor_ctrl
   import panel_cursor_pkg::*;
#(
   parameter int                    COLS            = 16,
   parameter int                    ROWS            = 2,
   parameter logic [COLS*ROWS-1:0]  MOMENTARY_MASK  = 32'hFE7C0000,
   parameter int                    MIN_HOLD_CYCLES = 16,
   localparam int                   IDX_W           = clog2_min1(COLS*ROWS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [10:0]      ps2_key,
   output logic [IDX_W-1:0] cursor_index,
   output logic [1:0]       cursor_action,
   output logic             cursor_strobe,
   output logic             cursor_busy
);

   localparam int COL_W  = clog2_min1(COLS);
   localparam int ROW_W  = clog2_min1(ROWS);
   localparam int HOLD_W = clog2_min1(MIN_HOLD_CYCLES + 1);

   localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(ROWS - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_CYCLES);

   logic             key_evt;
   logic             key_make;
   logic [7:0]       key_code;

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   action_e           action_q, action_d;
   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [7:0]        held_code_q, held_code_d;
   logic              strobe_q, strobe_d;

   logic [COL_W-1:0]  col_minus, col_plus;
   logic [ROW_W-1:0]  row_minus, row_plus;
   logic [HOLD_W-1:0] hold_inc;
   logic              hold_done;
   logic [IDX_W-1:0]  cur_index, next_index;

   ps2_key_event u_key_event (
      .clk      (clk),
      .reset    (reset),
      .ps2_key  (ps2_key),
      .key_evt  (key_evt),
      .key_make (key_make),
      .key_code (key_code)
   );

   // Neighbour coordinates for the four arrow keys. Comparing against the
   // last legal column/row (rather than relying on counter roll-over) keeps
   // non-power-of-two grids from ever producing an out-of-range coordinate.
   always_comb begin
`ifdef CURSOR_WRAP_EN
      col_minus = (col_q == '0)      ? COL_MAX : col_q - COL_W'(1);
      col_plus  = (col_q >= COL_MAX) ? '0      : col_q + COL_W'(1);
      row_minus = (row_q == '0)      ? ROW_MAX : row_q - ROW_W'(1);
      row_plus  = (row_q >= ROW_MAX) ? '0      : row_q + ROW_W'(1);
`else
      col_minus = (col_q == '0)      ? '0      : col_q - COL_W'(1);
      col_plus  = (col_q >= COL_MAX) ? COL_MAX : col_q + COL_W'(1);
      row_minus = (row_q == '0)      ? '0      : row_q - ROW_W'(1);
      row_plus  = (row_q >= ROW_MAX) ? ROW_MAX : row_q + ROW_W'(1);
`endif
   end

   // hold_inc is the hold count as it will be after this clock. Judging the
   // release against it means a switch is on for exactly MIN_HOLD_CYCLES
   // clocks when the key comes up early, counted from the make update.
   always_comb begin
      hold_inc  = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + HOLD_W'(1);
      hold_done = (hold_inc >= HOLD_MAX);
      cur_index = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
   end

   // Next-state logic. In IDLE every recognised make is acted on; a 1/2 on
   // a momentary switch additionally locks the cursor in HELD until the same
   // key is released (or 0 is pressed). REL_WAIT only waits out the minimum
   // hold, swallowing any key traffic, including one arriving on the expiry
   // clock itself.
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      action_d    = action_q;
      state_d     = state_q;
      hold_d      = hold_q;
      held_code_d = held_code_q;

      unique case (state_q)
         IDLE: begin
            hold_d = '0;
            if (key_evt && key_make) begin
               case (key_code)
                  KEY_UP: begin
                     row_d    = row_minus;
                     action_d = ACT_MOVE;
                  end
                  KEY_DN: begin
                     row_d    = row_plus;
                     action_d = ACT_MOVE;
                  end
                  KEY_LT: begin
                     col_d    = col_minus;
                     action_d = ACT_MOVE;
                  end
                  KEY_RT: begin
                     col_d    = col_plus;
                     action_d = ACT_MOVE;
                  end
                  KEY_0: begin
                     action_d = ACT_OFF;
                  end
                  KEY_1, KEY_2: begin
                     action_d = (key_code == KEY_1) ? ACT_ON : ACT_ALT;
                     if (MOMENTARY_MASK[cur_index]) begin
                        state_d     = HELD;
                        held_code_d = key_code;
                        hold_d      = '0;
                     end
                  end
                  default: ;
               endcase
            end
         end

         HELD: begin
            hold_d = hold_inc;
            if (key_evt) begin
               if (key_make && key_code == KEY_0) begin
                  action_d = ACT_OFF;
                  state_d  = IDLE;
               end else if (!key_make && key_code == held_code_q) begin
                  if (hold_done) begin
                     action_d = ACT_OFF;
                     state_d  = IDLE;
                  end else begin
                     state_d = REL_WAIT;
                  end
               end
            end
         end

         REL_WAIT: begin
            hold_d = hold_inc;
            if (hold_done) begin
               action_d = ACT_OFF;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      next_index = IDX_W'(row_d) * IDX_W'(COLS) + IDX_W'(col_d);
      strobe_d   = (next_index != cur_index) || (action_d != action_q);
   end

   // State and output registers. The strobe is registered alongside the
   // action/position so it lands in the same cycle the new values appear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         action_q    <= ACT_OFF;
         state_q     <= IDLE;
         hold_q      <= '0;
         held_code_q <= 8'h00;
         strobe_q    <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         action_q    <= action_d;
         state_q     <= state_d;
         hold_q      <= hold_d;
         held_code_q <= held_code_d;
         strobe_q    <= strobe_d;
      end
   end

   assign cursor_index  = cur_index;
   assign cursor_action = action_q;
   assign cursor_strobe = strobe_q;
   assign cursor_busy   = (state_q != IDLE);

endmodule
